// File: rtl/tic_tac_toe_auto_player.sv
// Automated tic-tac-toe opponent: watches the game core's board flags and presses one free cell per turn.
// Macro AUTO_PLAYER_STRATEGY_EN selects win > block > centre > corner > edge play; otherwise lowest free cell.
module tic_tac_toe_auto_player #(
    parameter int unsigned PLAYER         = 1,
    parameter int unsigned PRESS_CYCLES   = 4,
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       p1_turn,
    input  logic       p2_turn,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       grid_full,
    input  logic [8:0] cell_led,
    output logic [8:0] press,
    output logic       busy,
    output logic [3:0] move_idx,
    output logic [8:0] own_mask,
    output logic       timeout_err
);

    localparam int unsigned MAX_PR  = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_PR > TIMEOUT_CYCLES) ? MAX_PR : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_PRESS,
        ST_RELEASE,
        ST_CONFIRM
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8:0]         press_q, press_d;
    logic               busy_q, busy_d;
    logic [3:0]         move_idx_q, move_idx_d;
    logic [8:0]         own_mask_q, own_mask_d;
    logic               timeout_err_q, timeout_err_d;

    logic               game_over_c;
    logic               my_turn_c;
    logic [8:0]         free_c;
    logic [3:0]         choice_c;
    logic [15:0]        led_ext_c;
    logic               confirm_c;

    function automatic logic [3:0] lowest_idx(input logic [8:0] v);
        lowest_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

    assign game_over_c = p1_win | p2_win | grid_full;
    assign my_turn_c   = (PLAYER == 1) ? p1_turn : p2_turn;
    assign free_c      = ~cell_led;
    assign led_ext_c   = 16'(cell_led);
    assign confirm_c   = led_ext_c[move_idx_q] & ~my_turn_c;

`ifdef AUTO_PLAYER_STRATEGY_EN
    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };
    localparam logic [8:0] CORNERS = 9'h145;
    localparam logic [8:0] EDGES   = 9'h0AA;

    logic [8:0] opp_mask_c;
    logic [8:0] win_c;
    logic [8:0] block_c;

    // Free cells that would complete a line whose other two cells belong to holder.
    function automatic logic [8:0] line_fill(input logic [8:0] holder, input logic [8:0] free);
        logic [15:0] h;
        logic [15:0] f;
        logic [15:0] fill;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  c;
        h    = 16'(holder);
        f    = 16'(free);
        fill = '0;
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < 3; k++) begin
                a = LINES[l][k];
                b = LINES[l][(k + 1) % 3];
                c = LINES[l][(k + 2) % 3];
                fill[a] = fill[a] | (f[a] & h[b] & h[c]);
            end
        end
        line_fill = 9'(fill);
    endfunction

    assign opp_mask_c = cell_led & ~own_mask_q;
    assign win_c      = line_fill(own_mask_q, free_c);
    assign block_c    = line_fill(opp_mask_c, free_c);

    always_comb begin
        choice_c = 4'd0;
        if (|win_c)                   choice_c = lowest_idx(win_c);
        else if (|block_c)            choice_c = lowest_idx(block_c);
        else if (free_c[4])           choice_c = 4'd4;
        else if (|(free_c & CORNERS)) choice_c = lowest_idx(free_c & CORNERS);
        else                          choice_c = lowest_idx(free_c & EDGES);
    end
`else
    assign choice_c = lowest_idx(free_c);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            press_q       <= '0;
            busy_q        <= 1'b0;
            move_idx_q    <= 4'd0;
            own_mask_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_q       <= press_d;
            busy_q        <= busy_d;
            move_idx_q    <= move_idx_d;
            own_mask_q    <= own_mask_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Move sequencing; a finished game abandons any move in flight.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        move_idx_d    = move_idx_q;
        own_mask_d    = own_mask_q;
        timeout_err_d = timeout_err_q;
        if ((state_q != ST_IDLE) && game_over_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && my_turn_c && !game_over_c && (|free_c)) begin
                        state_d = ST_DECIDE;
                        cnt_d   = '0;
                    end
                end
                ST_DECIDE: begin
                    cnt_d = '0;
                    if (|free_c) begin
                        move_idx_d = choice_c;
                        state_d    = ST_PRESS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if (cnt_q == CNT_W'(PRESS_CYCLES - 1)) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
                        state_d = ST_CONFIRM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (confirm_c) begin
                        own_mask_d = own_mask_q | 9'(16'd1 << move_idx_q);
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // An empty board means the core started a new game.
        if (cell_led == 9'd0) own_mask_d = '0;
        press_d = (state_d == ST_PRESS) ? 9'(16'd1 << move_idx_d) : 9'd0;
        busy_d  = (state_d != ST_IDLE);
    end

    assign press       = press_q;
    assign busy        = busy_q;
    assign move_idx    = move_idx_q;
    assign own_mask    = own_mask_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tic_tac_toe_auto_player.sv
// Bench for tic_tac_toe_auto_player: the bench acts as game core and random opponent,
// predicting each chosen cell from the game rules.
module tb_tic_tac_toe_auto_player;

    localparam int unsigned P = 4;
    localparam int unsigned R = 4;
    localparam int unsigned T = 64;

    logic       clk = 1'b0;
    logic       reset, enable, p1_turn, p2_turn, p1_win, p2_win, grid_full;
    logic [8:0] cell_led, press, own_mask;
    logic       busy, timeout_err;
    logic [3:0] move_idx;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] mine, theirs;
    logic       exp_terr;

    always #5 clk = ~clk;

    tic_tac_toe_auto_player #(
        .PLAYER(1), .PRESS_CYCLES(P), .RELEASE_CYCLES(R), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .p1_turn(p1_turn), .p2_turn(p2_turn),
        .p1_win(p1_win), .p2_win(p2_win), .grid_full(grid_full),
        .cell_led(cell_led), .press(press), .busy(busy),
        .move_idx(move_idx), .own_mask(own_mask), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // True when cell c plus two other cells held in m would form a row, column or diagonal.
    function automatic bit completes(input int c, input logic [8:0] m);
        int r = c / 3;
        int k = c % 3;
        int n;
        n = 0;
        for (int j = 0; j < 3; j++) if (j != k && m[r * 3 + j]) n++;
        if (n == 2) return 1'b1;
        n = 0;
        for (int j = 0; j < 3; j++) if (j != r && m[j * 3 + k]) n++;
        if (n == 2) return 1'b1;
        if (r == k) begin
            n = 0;
            for (int j = 0; j < 3; j++) if (j != r && m[j * 4]) n++;
            if (n == 2) return 1'b1;
        end
        if (r + k == 2) begin
            n = 0;
            for (int j = 0; j < 3; j++) if (j != r && m[j * 2 + 2]) n++;
            if (n == 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit has_line(input logic [8:0] m);
        for (int c = 0; c < 9; c++) if (m[c] && completes(c, m)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_choice(input logic [8:0] me, input logic [8:0] opp);
        logic [8:0] fr;
        int corners[4] = '{0, 2, 6, 8};
        int edges[4]   = '{1, 3, 5, 7};
        fr = ~(me | opp);
`ifdef AUTO_PLAYER_STRATEGY_EN
        for (int c = 0; c < 9; c++) if (fr[c] && completes(c, me)) return c;
        for (int c = 0; c < 9; c++) if (fr[c] && completes(c, opp)) return c;
        if (fr[4]) return 4;
        foreach (corners[i]) if (fr[corners[i]]) return corners[i];
        foreach (edges[i]) if (fr[edges[i]]) return edges[i];
`else
        for (int c = 0; c < 9; c++) if (fr[c]) return c;
`endif
        return -1;
    endfunction

    // mode 0: core confirms; mode 1: core never lights the cell; mode 2: opponent win during press
    task automatic do_move(input int mode);
        int         c;
        int         n;
        logic [8:0] bitv;
        bit         done;
        bit         aborted;
        c       = model_choice(mine, theirs);
        bitv    = 9'd1 << c;
        aborted = 1'b0;
        p1_turn = 1'b1;
        tick();
        check("decide_busy", busy, 1);
        check("decide_press", press, 0);
        enable = 1'($urandom_range(0, 1));
        for (int k = 0; k < int'(P) && !aborted; k++) begin
            tick();
            check("press_on", press, bitv);
            if (mode == 2 && k == 1) begin
                p2_win  = 1'b1;
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            tick();
            check("abort_press", press, 0);
            check("abort_busy", busy, 0);
            check("abort_own", own_mask, mine);
            p1_turn = 1'b0;
        end else begin
            tick();
            check("press_off", press, 0);
            n = int'(P);
            if (mode == 0) begin
                cell_led[c] = 1'b1;
                p1_turn     = 1'b0;
            end
            done = 1'b0;
            for (int w = 0; w < 200 && !done; w++) begin
                tick();
                n++;
                if (!busy) done = 1'b1;
            end
            p1_turn = 1'b0;
            check("move_done", done, 1);
            if (mode == 0) begin
                mine[c] = 1'b1;
                check("confirm_lat", n, P + R + 1);
            end else begin
                exp_terr = 1'b1;
                check("timeout_lat", n, P + R + T);
            end
            check("move_idx", move_idx, c);
            check("own_mask", own_mask, mine);
            check("timeout_err", timeout_err, exp_terr);
        end
        enable = 1'b1;
    endtask

    task automatic new_game();
        cell_led  = '0;
        p1_win    = 1'b0;
        p2_win    = 1'b0;
        grid_full = 1'b0;
        p1_turn   = 1'b0;
        p2_turn   = 1'b0;
        mine      = '0;
        theirs    = '0;
        tick();
        check("new_game_own", own_mask, 0);
        check("new_game_busy", busy, 0);
    endtask

    task automatic opp_move();
        int start;
        int c;
        start = $urandom_range(0, 8);
        c     = start;
        for (int i = 0; i < 9; i++) begin
            if (!cell_led[(start + i) % 9]) begin
                c = (start + i) % 9;
                break;
            end
        end
        p2_turn = 1'b1;
        tick();
        check("opp_turn_busy", busy, 0);
        check("opp_turn_press", press, 0);
        cell_led[c] = 1'b1;
        theirs[c]   = 1'b1;
        p2_turn     = 1'b0;
    endtask

    // special: 0 normal game, 1 timeout on first own move, 2 abort on first own move
    task automatic play_game(input int special, input bit me_first);
        bit my_go;
        bit over;
        my_go = me_first;
        over  = 1'b0;
        new_game();
        while (!over) begin
            if (my_go) begin
                if ($urandom_range(0, 3) == 0) begin
                    enable  = 1'b0;
                    p1_turn = 1'b1;
                    tick();
                    tick();
                    check("disabled_idle", busy, 0);
                    enable  = 1'b1;
                end
                if (special == 1) begin
                    do_move(1);
                    p2_win = 1'b1;
                    over   = 1'b1;
                end else if (special == 2) begin
                    do_move(2);
                    over = 1'b1;
                end else begin
                    do_move(0);
                    if (has_line(mine)) begin
                        p1_win = 1'b1;
                        over   = 1'b1;
                    end
                end
            end else begin
                opp_move();
                if (has_line(theirs)) begin
                    p2_win = 1'b1;
                    over   = 1'b1;
                end
            end
            if (!over && (mine | theirs) == 9'h1FF) begin
                grid_full = 1'b1;
                over      = 1'b1;
            end
            my_go = !my_go;
        end
        p1_turn = 1'b1;
        tick();
        tick();
        check("gameover_idle", busy, 0);
        check("gameover_press", press, 0);
        p1_turn = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        p1_turn   = 1'b0;
        p2_turn   = 1'b0;
        p1_win    = 1'b0;
        p2_win    = 1'b0;
        grid_full = 1'b0;
        cell_led  = '0;
        mine      = '0;
        theirs    = '0;
        exp_terr  = 1'b0;
        tick();
        tick();
        check("rst_press", press, 0);
        check("rst_busy", busy, 0);
        check("rst_own", own_mask, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_move_idx", move_idx, 0);
        reset = 1'b1;

        play_game(0, 1'b1);
        play_game(0, 1'b0);
        play_game(2, 1'b0);
        play_game(1, 1'b1);
        for (int g = 0; g < 30; g++) play_game(0, 1'($urandom_range(0, 1)));

        reset = 1'b0;
        tick();
        check("final_rst_terr", timeout_err, 0);
        check("final_rst_own", own_mask, 0);
        check("final_rst_busy", busy, 0);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tic_tac_toe_auto_player.md
# tic_tac_toe_auto_player

Automated opponent that drives the game core's nine cell pushbutton inputs from the board status it outputs. It reads the turn, win and grid-full flags and the nine cell LEDs, chooses a free cell on its own turn and emits a debounced-width press pulse on that cell's button line. It tracks which lit cells it owns, because the core's LEDs show occupancy only and not ownership. It sits beside the game core in place of one human player.

## Interface
Parameters:
- PLAYER, 1: side played; 1 → acts on p1_turn, 2 → acts on p2_turn.
- PRESS_CYCLES, 4: cycles the press line is held high (≥1).
- RELEASE_CYCLES, 4: cycles held low after release before confirm (≥1).
- TIMEOUT_CYCLES, 64: confirm-wait limit (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = player may move; sampled only in IDLE.
- p1_turn, p2_turn  in  1 each  turn flags from the game core.
- p1_win, p2_win, grid_full  in  1 each  game-over flags.
- cell_led  in  9  occupancy; bit0=a … bit8=i, row-major.
- press  out  9  one-hot button drive, same bit mapping.
- busy  out  1  high in any state other than IDLE.
- move_idx  out  4  last chosen cell, 0–8.
- own_mask  out  9  cells this player occupies.
- timeout_err  out  1  sticky; set on confirm timeout.

## Operation
- Reset (reset=0 at an edge): state=IDLE, press=0, busy=0, move_idx=0, own_mask=0, timeout_err=0, all counters=0.
- game_over = p1_win | p2_win | grid_full. my_turn = (PLAYER==1 ? p1_turn : p2_turn).
- opp_mask = cell_led & ~own_mask. free = ~cell_led.
- States:
  - IDLE → DECIDE when enable & my_turn & ~game_over & (free≠0).
  - DECIDE (1 cycle): latch move_idx = choice → PRESS.
  - PRESS: press[move_idx]=1 for PRESS_CYCLES cycles → RELEASE.
  - RELEASE: press=0 for RELEASE_CYCLES cycles → CONFIRM.
  - CONFIRM: when cell_led[move_idx]=1 and my_turn=0, set own_mask[move_idx]=1 → IDLE. After TIMEOUT_CYCLES cycles without that condition: timeout_err=1, own_mask unchanged → IDLE.
- game_over in any non-IDLE state: press=0 the next cycle, → IDLE, no own_mask update.
- cell_led==0 in any state (new game after a core reset): own_mask cleared. timeout_err is cleared only by reset.
- Choice with strategy (see Configuration). Lines are the 3 rows, 3 columns and 2 diagonals. Ties go to the lowest cell index.
  1. A free cell completing a line where the other two cells are in own_mask.
  2. A free cell completing a line where the other two cells are in opp_mask.
  3. Centre (4).
  4. Corners in order 0, 2, 6, 8.
  5. Edges in order 1, 3, 5, 7.
- Choice without strategy: lowest-index free cell.
- press is never asserted on an occupied cell, and never on more than one bit.

## Timing
- my_turn rising at edge N (IDLE) → DECIDE at N+1 → press high from N+2 through N+1+PRESS_CYCLES.
- Press-to-confirm minimum: PRESS_CYCLES + RELEASE_CYCLES + 1 cycles.
- Outputs are registered; no combinational path from inputs to press.
- enable deasserted mid-move does not abort the move; it only blocks the next move.
- Reset takes priority over game_over and over every state transition.

## Configuration
- AUTO_PLAYER_STRATEGY_EN defined: priority chain win > block > centre > corner > edge.
- AUTO_PLAYER_STRATEGY_EN undefined: lowest-index free cell. The line-evaluation logic is not compiled.
- The interface is identical in both builds.

## Test plan
- Reset: hold reset=0 for 2 cycles → press=0, busy=0, own_mask=0, timeout_err=0.
- Empty board, PLAYER=1, p1_turn=1, enable=1 → strategy build: press=9'h010 (cell e) for exactly 4 cycles starting 2 cycles after p1_turn. Non-strategy build: press=9'h001.
- Win: own_mask=9'h003 (a, b), cell_led=9'h01B, my turn → press=9'h004 (c).
- Block: own_mask=9'h010, cell_led=9'h019 (opponent holds a, d), no own win available → press=9'h040 (g).
- Core mock lights the cell and drops p1_turn → own_mask bit set, busy=0. Mock never lights the cell → timeout_err=1 after 4+4+64 cycles and state returns to IDLE.
- p2_win=1 asserted during PRESS → press=0 the next cycle, busy=0, own_mask unchanged. Then cell_led=0 → own_mask=0.
